// File: rtl/router_lpm_mc.sv
// Multi-channel longest-prefix-match lookup: round-robin arbitration of N_CH requesters
// into a 2-stage pipeline over a runtime-configured register table.
module router_lpm_mc #(
   parameter int unsigned N_CH   = 4,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned PORT_W = 16,
   parameter int unsigned IP_W   = 32,
   localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_CH-1:0]      lkp_valid,
   output logic [N_CH-1:0]      lkp_ready,
   input  logic [N_CH*IP_W-1:0] lkp_dst_ip,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [CH_W-1:0]      resp_ch,
   output logic                 resp_found,
   output logic                 resp_is_default,
   output logic [IDX_W-1:0]     resp_idx,
   output logic [PORT_W-1:0]    resp_out_port,
   output logic [IP_W-1:0]      resp_next_hop_ip,
   input  logic                 cfg_wr,
   input  logic [IDX_W-1:0]     cfg_idx,
   input  logic                 cfg_entry_valid,
   input  logic [IP_W-1:0]      cfg_prefix,
   input  logic [5:0]           cfg_prefix_len,
   input  logic [PORT_W-1:0]    cfg_out_port,
   input  logic [IP_W-1:0]      cfg_next_hop_ip,
   input  logic                 cfg_clear,
   output logic [31:0]          stat_lookups,
   output logic [31:0]          stat_misses
);

   localparam logic [5:0]      LEN_MAX = 6'(IP_W);
   localparam logic [IP_W-1:0] ONES    = '1;

   logic [DEPTH-1:0]  tbl_valid_q;
   logic [IP_W-1:0]   tbl_prefix_q [DEPTH];
   logic [5:0]        tbl_len_q    [DEPTH];
   logic [PORT_W-1:0] tbl_port_q   [DEPTH];
   logic [IP_W-1:0]   tbl_nh_q     [DEPTH];
   logic [5:0]        cfg_len_clamped;

   logic              stall, accept, grant_vld;
   logic [CH_W-1:0]   grant, rr_q, rr_d;

   logic              s1_valid_q, s1_valid_d;
   logic [CH_W-1:0]   s1_ch_q, s1_ch_d;
   logic [IP_W-1:0]   s1_ip_q, s1_ip_d;

   logic              hit;
   logic [5:0]        best_len;
   logic [IDX_W-1:0]  best_idx;

   logic              resp_valid_q, resp_valid_d;
   logic [CH_W-1:0]   resp_ch_q, resp_ch_d;
   logic              resp_found_q, resp_found_d;
   logic              resp_dflt_q, resp_dflt_d;
   logic [IDX_W-1:0]  resp_idx_q, resp_idx_d;
   logic [PORT_W-1:0] resp_port_q, resp_port_d;
   logic [IP_W-1:0]   resp_nh_q, resp_nh_d;
   logic [31:0]       stat_lookups_q, stat_misses_q;

   // ---------------- routing table ----------------
   always_comb cfg_len_clamped = (cfg_prefix_len > LEN_MAX) ? LEN_MAX : cfg_prefix_len;

   // Clear dominates a same-cycle write.
   always_ff @(posedge clk) begin
      if (rst || cfg_clear) tbl_valid_q <= '0;
      else if (cfg_wr)      tbl_valid_q[cfg_idx] <= cfg_entry_valid;
   end

   always_ff @(posedge clk) begin
      if (cfg_wr && !cfg_clear) begin
         tbl_prefix_q[cfg_idx] <= cfg_prefix;
         tbl_len_q[cfg_idx]    <= cfg_len_clamped;
         tbl_port_q[cfg_idx]   <= cfg_out_port;
         tbl_nh_q[cfg_idx]     <= cfg_next_hop_ip;
      end
   end

   // ---------------- stage 0: round-robin arbitration ----------------
   assign stall  = resp_valid_q & ~resp_ready;
   assign accept = grant_vld & ~stall;

   always_comb begin
      int unsigned c;
      c         = 0;
      grant     = '0;
      grant_vld = 1'b0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         c = 32'(rr_q) + k;
         if (c >= N_CH) c = c - N_CH;
         if (!grant_vld && lkp_valid[CH_W'(c)]) begin
            grant_vld = 1'b1;
            grant     = CH_W'(c);
         end
      end
   end

   always_comb begin
      lkp_ready = '0;
      if (accept) lkp_ready[grant] = 1'b1;
   end

   always_comb begin
      rr_d = rr_q;
      if (accept) rr_d = (32'(grant) == N_CH - 1) ? '0 : grant + 1'b1;
   end

   // ---------------- stage 1: prefix compare, longest wins, lowest index on ties ----------------
   always_comb begin
      logic [IP_W-1:0] mask;
      mask     = '0;
      hit      = 1'b0;
      best_len = '0;
      best_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mask = ~(ONES >> tbl_len_q[IDX_W'(i)]);
         if (tbl_valid_q[IDX_W'(i)] &&
             (((s1_ip_q ^ tbl_prefix_q[IDX_W'(i)]) & mask) == '0) &&
             (!hit || tbl_len_q[IDX_W'(i)] > best_len)) begin
            hit      = 1'b1;
            best_len = tbl_len_q[IDX_W'(i)];
            best_idx = IDX_W'(i);
         end
      end
   end

   // A stalled S1 entry is recompared every cycle, so table writes during a stall reach it.
   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_ch_d      = s1_ch_q;
      s1_ip_d      = s1_ip_q;
      resp_valid_d = resp_valid_q;
      resp_ch_d    = resp_ch_q;
      resp_found_d = resp_found_q;
      resp_dflt_d  = resp_dflt_q;
      resp_idx_d   = resp_idx_q;
      resp_port_d  = resp_port_q;
      resp_nh_d    = resp_nh_q;
      if (!stall) begin
         s1_valid_d   = accept;
         s1_ch_d      = grant;
         s1_ip_d      = lkp_dst_ip[grant * IP_W +: IP_W];
         resp_valid_d = s1_valid_q;
         resp_ch_d    = s1_ch_q;
         resp_found_d = hit;
         resp_dflt_d  = hit && (best_len == '0);
         resp_idx_d   = best_idx;
         resp_port_d  = hit ? tbl_port_q[best_idx] : '0;
         resp_nh_d    = hit ? tbl_nh_q[best_idx] : '0;
      end
   end

   // ---------------- pipeline registers and statistics ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q           <= '0;
         s1_valid_q     <= 1'b0;
         s1_ch_q        <= '0;
         s1_ip_q        <= '0;
         resp_valid_q   <= 1'b0;
         resp_ch_q      <= '0;
         resp_found_q   <= 1'b0;
         resp_dflt_q    <= 1'b0;
         resp_idx_q     <= '0;
         resp_port_q    <= '0;
         resp_nh_q      <= '0;
         stat_lookups_q <= '0;
         stat_misses_q  <= '0;
      end else begin
         rr_q         <= rr_d;
         s1_valid_q   <= s1_valid_d;
         s1_ch_q      <= s1_ch_d;
         s1_ip_q      <= s1_ip_d;
         resp_valid_q <= resp_valid_d;
         resp_ch_q    <= resp_ch_d;
         resp_found_q <= resp_found_d;
         resp_dflt_q  <= resp_dflt_d;
         resp_idx_q   <= resp_idx_d;
         resp_port_q  <= resp_port_d;
         resp_nh_q    <= resp_nh_d;
         if (resp_valid_q && resp_ready) begin
            stat_lookups_q <= stat_lookups_q + 32'd1;
            if (!resp_found_q) stat_misses_q <= stat_misses_q + 32'd1;
         end
      end
   end

   assign resp_valid       = resp_valid_q;
   assign resp_ch          = resp_ch_q;
   assign resp_found       = resp_found_q;
   assign resp_is_default  = resp_dflt_q;
   assign resp_idx         = resp_idx_q;
   assign resp_out_port    = resp_port_q;
   assign resp_next_hop_ip = resp_nh_q;
   assign stat_lookups     = stat_lookups_q;
   assign stat_misses      = stat_misses_q;

endmodule

// File: tb/tb_router_lpm_mc.sv
// Randomized and directed bench for router_lpm_mc against a transaction-level reference
// model (route table arrays, two pipeline slots, spec-level LPM and round-robin rules).
module tb_router_lpm_mc;
   localparam int N_CH = 4, DEPTH = 16, PORT_W = 16, IP_W = 32, CH_W = 2, IDX_W = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N_CH-1:0]      lkp_valid, lkp_ready;
   logic [N_CH*IP_W-1:0] lkp_dst_ip;
   logic                 resp_valid, resp_ready, resp_found, resp_is_default;
   logic [CH_W-1:0]      resp_ch;
   logic [IDX_W-1:0]     resp_idx;
   logic [PORT_W-1:0]    resp_out_port;
   logic [IP_W-1:0]      resp_next_hop_ip;
   logic                 cfg_wr, cfg_entry_valid, cfg_clear;
   logic [IDX_W-1:0]     cfg_idx;
   logic [IP_W-1:0]      cfg_prefix, cfg_next_hop_ip;
   logic [5:0]           cfg_prefix_len;
   logic [PORT_W-1:0]    cfg_out_port;
   logic [31:0]          stat_lookups, stat_misses;

   always #5 clk = ~clk;

   router_lpm_mc #(.N_CH(N_CH), .DEPTH(DEPTH), .PORT_W(PORT_W), .IP_W(IP_W)) dut (
      .clk(clk), .rst(rst),
      .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_dst_ip(lkp_dst_ip),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ch(resp_ch),
      .resp_found(resp_found), .resp_is_default(resp_is_default), .resp_idx(resp_idx),
      .resp_out_port(resp_out_port), .resp_next_hop_ip(resp_next_hop_ip),
      .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_entry_valid(cfg_entry_valid),
      .cfg_prefix(cfg_prefix), .cfg_prefix_len(cfg_prefix_len), .cfg_out_port(cfg_out_port),
      .cfg_next_hop_ip(cfg_next_hop_ip), .cfg_clear(cfg_clear),
      .stat_lookups(stat_lookups), .stat_misses(stat_misses)
   );

   int n_chk = 0, n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      bit          v;
      int unsigned ch;
      bit          found;
      bit          dflt;
      int unsigned idx;
      int unsigned port;
      int unsigned nh;
   } rsp_t;

   bit          m_v    [DEPTH];
   int unsigned m_pfx  [DEPTH];
   int unsigned m_len  [DEPTH];
   int unsigned m_port [DEPTH];
   int unsigned m_nh   [DEPTH];
   bit          m_s1_v;
   int unsigned m_s1_ch, m_s1_ip;
   rsp_t        m_s2;
   int unsigned m_ptr, m_lk, m_ms;

   int          grant_last, done_cnt;
   longint      cyc, grant_cyc, done_cyc;
   logic [N_CH-1:0] obs_ready;
   logic        l_found, l_dflt;
   logic [63:0] l_ch, l_idx, l_port, l_nh;

   function automatic rsp_t ref_lookup(int unsigned ch, int unsigned ip);
      rsp_t r;
      r    = '0;
      r.v  = 1'b1;
      r.ch = ch;
      for (int i = 0; i < DEPTH; i++)
         if (m_v[i] && (m_len[i] == 0 || ((ip ^ m_pfx[i]) >> (32 - m_len[i])) == 0))
            if (!r.found || m_len[i] > m_len[r.idx]) begin
               r.found = 1'b1;
               r.idx   = i;
            end
      if (r.found) begin
         r.port = m_port[r.idx];
         r.nh   = m_nh[r.idx];
         r.dflt = (m_len[r.idx] == 0);
      end
      return r;
   endfunction

   function automatic void model_reset();
      foreach (m_v[i]) m_v[i] = 1'b0;
      m_s1_v = 1'b0; m_s1_ch = 0; m_s1_ip = 0;
      m_s2 = '0; m_ptr = 0; m_lk = 0; m_ms = 0;
   endfunction

   // Check outputs, advance the model by one edge, return at the following negedge.
   task automatic tick();
      bit          stall_m, gv, acc;
      int unsigned g, bestd, d;
      #1;
      stall_m = m_s2.v && !resp_ready;
      gv = 1'b0; g = 0; bestd = N_CH;
      for (int c = 0; c < N_CH; c++)
         if (lkp_valid[c]) begin
            d = (c + N_CH - m_ptr) % N_CH;
            if (d < bestd) begin bestd = d; g = c; gv = 1'b1; end
         end
      acc = gv && !stall_m;
      check("lkp_ready", lkp_ready, acc ? (64'd1 << g) : 64'd0);
      check("resp_valid", resp_valid, m_s2.v);
      if (m_s2.v) begin
         check("resp_ch", resp_ch, m_s2.ch);
         check("resp_found", resp_found, m_s2.found);
         check("resp_is_default", resp_is_default, m_s2.dflt);
         check("resp_idx", resp_idx, m_s2.idx);
         check("resp_out_port", resp_out_port, m_s2.port);
         check("resp_next_hop_ip", resp_next_hop_ip, m_s2.nh);
      end
      check("stat_lookups", stat_lookups, m_lk);
      check("stat_misses", stat_misses, m_ms);
      obs_ready = lkp_ready;
      if (resp_valid && resp_ready) begin
         l_found = resp_found; l_dflt = resp_is_default; l_ch = resp_ch;
         l_idx = resp_idx; l_port = resp_out_port; l_nh = resp_next_hop_ip;
         done_cnt++; done_cyc = cyc;
      end
      grant_last = acc ? int'(g) : -1;
      if (acc) grant_cyc = cyc;
      if (rst) model_reset();
      else begin
         if (m_s2.v && resp_ready) begin m_lk++; if (!m_s2.found) m_ms++; end
         if (!stall_m) begin
            m_s2 = m_s1_v ? ref_lookup(m_s1_ch, m_s1_ip) : '0;
            m_s1_v = acc; m_s1_ch = g; m_s1_ip = lkp_dst_ip[g*IP_W +: IP_W];
            if (acc) m_ptr = (g + 1) % N_CH;
         end
         if (cfg_clear) foreach (m_v[i]) m_v[i] = 1'b0;
         else if (cfg_wr) begin
            m_v[cfg_idx]    = cfg_entry_valid;
            m_pfx[cfg_idx]  = cfg_prefix;
            m_len[cfg_idx]  = (cfg_prefix_len > 32) ? 32 : cfg_prefix_len;
            m_port[cfg_idx] = cfg_out_port;
            m_nh[cfg_idx]   = cfg_next_hop_ip;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   function automatic logic [31:0] ip4(int a, int b, int c, int d);
      return {8'(a), 8'(b), 8'(c), 8'(d)};
   endfunction

   function automatic logic [31:0] rnd_ip();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return {8'd10, 8'($urandom_range(0, 3)), 16'($urandom)};
         2:       return {12'hAC1, 20'($urandom)};
         default: return {16'hC0A8, 16'($urandom_range(0, 3))};
      endcase
   endfunction

   task automatic cfg_write(input int idx, input bit v, input logic [31:0] pfx, input int len,
                            input int port, input logic [31:0] nh);
      cfg_wr = 1'b1; cfg_idx = IDX_W'(idx); cfg_entry_valid = v; cfg_prefix = pfx;
      cfg_prefix_len = 6'(len); cfg_out_port = PORT_W'(port); cfg_next_hop_ip = nh;
      tick();
      cfg_wr = 1'b0;
   endtask

   task automatic do_lookup(input int ch, input logic [31:0] ip);
      bit acc;
      int d0;
      acc = 1'b0;
      d0 = done_cnt;
      lkp_valid[ch] = 1'b1;
      lkp_dst_ip[ch*IP_W +: IP_W] = ip;
      for (int n = 0; n < 20 && !acc; n++) begin
         tick();
         acc = (grant_last == ch);
      end
      lkp_valid[ch] = 1'b0;
      if (!acc) check("lkp_accept_timeout", 0, 1);
      for (int n = 0; n < 20 && done_cnt == d0; n++) tick();
      if (done_cnt == d0) check("resp_timeout", 0, 1);
   endtask

   int          pend [N_CH];
   logic [31:0] ipc  [N_CH];

   initial begin
      int d0, cnt, acc_n, done_n;
      rst = 1'b1; lkp_valid = '0; lkp_dst_ip = '0; resp_ready = 1'b1;
      cfg_wr = 1'b0; cfg_idx = '0; cfg_entry_valid = 1'b0; cfg_prefix = '0;
      cfg_prefix_len = '0; cfg_out_port = '0; cfg_next_hop_ip = '0; cfg_clear = 1'b0;
      cyc = 0; done_cnt = 0; grant_last = -1; grant_cyc = 0; done_cyc = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      model_reset();
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_found", resp_found, 0);
      check("rst_resp_idx", resp_idx, 0);
      check("rst_resp_port", resp_out_port, 0);
      check("rst_resp_nh", resp_next_hop_ip, 0);
      check("rst_lookups", stat_lookups, 0);
      check("rst_misses", stat_misses, 0);
      rst = 1'b0;

      do_lookup(0, ip4(10, 0, 0, 1));
      check("empty_found", l_found, 0);
      check("empty_ch", l_ch, 0);
      check("empty_latency", done_cyc - grant_cyc, 2);
      check("empty_misses", stat_misses, 1);

      cfg_write(3, 1, ip4(10, 0, 0, 0), 8, 2, ip4(1, 1, 1, 3));
      cfg_write(5, 1, ip4(10, 1, 0, 0), 16, 7, ip4(1, 1, 1, 5));
      cfg_write(0, 1, ip4(0, 0, 0, 0), 0, 9, ip4(1, 1, 1, 9));
      do_lookup(1, ip4(10, 1, 2, 3));
      check("l16_found", l_found, 1); check("l16_idx", l_idx, 5);
      check("l16_port", l_port, 7);   check("l16_dflt", l_dflt, 0);
      check("l16_ch", l_ch, 1);
      do_lookup(2, ip4(10, 9, 9, 9));
      check("l8_idx", l_idx, 3); check("l8_port", l_port, 2);
      do_lookup(3, ip4(192, 168, 1, 1));
      check("dflt_idx", l_idx, 0); check("dflt_port", l_port, 9); check("dflt_flag", l_dflt, 1);

      cfg_write(2, 1, ip4(172, 16, 0, 0), 12, 4, ip4(2, 2, 2, 2));
      cfg_write(6, 1, ip4(172, 16, 0, 0), 12, 8, ip4(6, 6, 6, 6));
      do_lookup(0, ip4(172, 16, 5, 5));
      check("tie_idx", l_idx, 2); check("tie_port", l_port, 4);

      cfg_write(8, 1, ip4(10, 1, 2, 4), 40, 12, ip4(8, 8, 8, 8));
      do_lookup(1, ip4(10, 1, 2, 4));
      check("clamp_idx", l_idx, 8); check("clamp_nh", l_nh, ip4(8, 8, 8, 8));
      do_lookup(2, ip4(10, 1, 2, 5));
      check("clamp_neighbour_idx", l_idx, 5);
      cfg_write(8, 0, ip4(10, 1, 2, 4), 32, 12, ip4(8, 8, 8, 8));
      do_lookup(3, ip4(10, 1, 2, 4));
      check("delete_idx", l_idx, 5);

      // All channels requesting continuously: one response per cycle.
      acc_n = 0; done_n = 0;
      for (int c = 0; c < N_CH; c++) lkp_dst_ip[c*IP_W +: IP_W] = rnd_ip();
      lkp_valid = '1; resp_ready = 1'b1;
      d0 = done_cnt;
      repeat (2) begin tick(); if (grant_last >= 0) acc_n++; end
      check("fill_resp", done_cnt - d0, 0);
      d0 = done_cnt;
      repeat (8) begin tick(); if (grant_last >= 0) acc_n++; end
      check("throughput", done_cnt - d0, 8);
      resp_ready = 1'b0; cnt = 0;
      repeat (5) begin tick(); if (obs_ready != 0) cnt++; if (grant_last >= 0) acc_n++; end
      check("stall_ready", cnt, 0);
      resp_ready = 1'b1;
      repeat (3) begin tick(); if (grant_last >= 0) acc_n++; end
      lkp_valid = '0;
      repeat (4) tick();
      check("no_loss", stat_lookups - 32'd8, 32'(acc_n));

      cfg_clear = 1'b1;
      cfg_write(1, 1, ip4(10, 1, 2, 0), 24, 3, ip4(3, 3, 3, 3));
      cfg_clear = 1'b0;
      do_lookup(1, ip4(10, 1, 2, 5));
      check("clr_found_a", l_found, 0);
      do_lookup(2, ip4(192, 168, 1, 1));
      check("clr_found_b", l_found, 0);

      lkp_dst_ip[0 +: IP_W] = ip4(10, 0, 0, 7);
      lkp_dst_ip[IP_W +: IP_W] = ip4(10, 0, 0, 8);
      lkp_valid = 4'b0011;
      repeat (2) tick();
      lkp_valid = '0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_valid", resp_valid, 0);
      check("midrst_lookups", stat_lookups, 0);
      check("midrst_misses", stat_misses, 0);
      repeat (4) tick();

      // Randomized traffic, backpressure and config churn.
      foreach (pend[c]) pend[c] = 0;
      for (int n = 0; n < 600; n++) begin
         for (int c = 0; c < N_CH; c++) begin
            if (pend[c] == 0 && $urandom_range(0, 2) == 0) begin pend[c] = 1; ipc[c] = rnd_ip(); end
            lkp_valid[c] = (pend[c] != 0);
            lkp_dst_ip[c*IP_W +: IP_W] = ipc[c];
         end
         resp_ready = ($urandom_range(0, 3) != 0);
         cfg_wr = ($urandom_range(0, 5) == 0);
         cfg_idx = IDX_W'($urandom_range(0, DEPTH - 1));
         cfg_entry_valid = ($urandom_range(0, 7) != 0);
         cfg_prefix = rnd_ip();
         cfg_prefix_len = 6'($urandom_range(0, 40));
         cfg_out_port = PORT_W'($urandom);
         cfg_next_hop_ip = $urandom;
         cfg_clear = ($urandom_range(0, 99) == 0);
         tick();
         if (grant_last >= 0) pend[grant_last] = 0;
      end
      cfg_wr = 1'b0; cfg_clear = 1'b0; lkp_valid = '0; resp_ready = 1'b1;
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
